// File: rtl/cfu_pkg.sv
// Shared definitions for the SIMD MAC custom function unit: opcodes,
// controller state encoding and the unknown-opcode response word.
package cfu_pkg;

  localparam logic [6:0] OP_MAC         = 7'd0;
  localparam logic [6:0] OP_SET_IN_OFF  = 7'd1;
  localparam logic [6:0] OP_SET_FLT_OFF = 7'd2;
  localparam logic [6:0] OP_READ        = 7'd3;
  localparam logic [6:0] OP_READ_CLR    = 7'd4;
  localparam logic [6:0] OP_CLR_ALL     = 7'd5;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/cfu_simd_lane_mul.sv
// One SIMD lane: sign-extends its element pair, applies the offsets and
// registers the 32-bit wrapped product when the command is accepted.
module cfu_simd_lane_mul #(
  parameter int ELEM_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  logic [31:0]       in_off,
  input  logic [31:0]       flt_off,
  output logic [31:0]       term
);

  logic [31:0] a_ext_s;
  logic [31:0] b_ext_s;
  logic [31:0] term_d;
  logic [31:0] term_q;

  // Low 32 bits of an unsigned product equal the wrapped signed product.
  always_comb begin
    a_ext_s = {{(32-ELEM_W){a[ELEM_W-1]}}, a};
    b_ext_s = {{(32-ELEM_W){b[ELEM_W-1]}}, b};
    if (load) begin
      term_d = (a_ext_s + in_off) * (b_ext_s + flt_off);
    end else begin
      term_d = term_q;
    end
  end

  // Multiplier stage register.
  always_ff @(posedge clk) begin
    if (reset) begin
      term_q <= 32'd0;
    end else begin
      term_q <= term_d;
    end
  end

  assign term = term_q;

endmodule

// File: rtl/cfu_simd_mac_banked.sv
// SIMD multiply-accumulate CFU with programmable offsets and NUM_ACC
// accumulator banks; one command in flight, IDLE -> EXEC -> RESP.
module cfu_simd_mac_banked
  import cfu_pkg::*;
#(
  parameter int ELEM_W  = 8,
  parameter int NUM_ACC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int LANES = 32 / ELEM_W;

  state_e      state_q, state_d;
  logic [6:0]  op_q, op_d;
  logic [2:0]  bank_q, bank_d;
  logic [31:0] set_val_q, set_val_d;
  logic [31:0] in_off_q, in_off_d;
  logic [31:0] flt_off_q, flt_off_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [31:0] acc_q [NUM_ACC];
  logic [31:0] acc_d [NUM_ACC];

  logic        accept_s;
  logic [31:0] term_s [LANES];
  logic [31:0] sum_s;
  logic [31:0] acc_sel_s;
  logic [31:0] acc_new_s;

  assign accept_s = cmd_valid & cmd_ready_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cfu_simd_lane_mul #(.ELEM_W(ELEM_W)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load    (accept_s),
      .a       (cmd_payload_inputs_0[g*ELEM_W +: ELEM_W]),
      .b       (cmd_payload_inputs_1[g*ELEM_W +: ELEM_W]),
      .in_off  (in_off_q),
      .flt_off (flt_off_q),
      .term    (term_s[g])
    );
  end

  // Adder tree over lane terms and selected-bank lookup.
  always_comb begin
    sum_s = 32'd0;
    for (int i = 0; i < LANES; i++) begin
      sum_s = sum_s + term_s[i];
    end
    acc_sel_s = 32'd0;
    for (int k = 0; k < NUM_ACC; k++) begin
      if (3'(k) == bank_q) begin
        acc_sel_s = acc_q[k];
      end else begin
        acc_sel_s = acc_sel_s;
      end
    end
    acc_new_s = acc_sel_s + sum_s;
  end

  // Controller next-state, commit of banks/offsets and response load.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    bank_d      = bank_q;
    set_val_d   = set_val_q;
    in_off_d    = in_off_q;
    flt_off_d   = flt_off_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    cmd_ready_d = cmd_ready_q;
    for (int k = 0; k < NUM_ACC; k++) begin
      acc_d[k] = acc_q[k];
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d     = ST_EXEC;
          cmd_ready_d = 1'b0;
          op_d        = cmd_payload_function_id[9:3];
          bank_d      = cmd_payload_function_id[2:0] & 3'(NUM_ACC - 1);
          set_val_d   = cmd_payload_inputs_0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        case (op_q)
          OP_MAC: begin
            rsp_data_d = acc_new_s;
            for (int k = 0; k < NUM_ACC; k++) begin
              if (3'(k) == bank_q) acc_d[k] = acc_new_s;
              else                 acc_d[k] = acc_q[k];
            end
          end
          OP_SET_IN_OFF: begin
            in_off_d   = set_val_q;
            rsp_data_d = 32'd0;
          end
          OP_SET_FLT_OFF: begin
            flt_off_d  = set_val_q;
            rsp_data_d = 32'd0;
          end
          OP_READ: begin
            rsp_data_d = acc_sel_s;
          end
          OP_READ_CLR: begin
            rsp_data_d = acc_sel_s;
            for (int k = 0; k < NUM_ACC; k++) begin
              if (3'(k) == bank_q) acc_d[k] = 32'd0;
              else                 acc_d[k] = acc_q[k];
            end
          end
          OP_CLR_ALL: begin
            rsp_data_d = 32'd0;
            for (int k = 0; k < NUM_ACC; k++) begin
              acc_d[k] = 32'd0;
            end
          end
          default: begin
            rsp_data_d = DEAD_BEEF;
          end
        endcase
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // State registers; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= 7'd0;
      bank_q      <= 3'd0;
      set_val_q   <= 32'd0;
      in_off_q    <= 32'd0;
      flt_off_q   <= 32'd0;
      rsp_data_q  <= 32'd0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      for (int k = 0; k < NUM_ACC; k++) begin
        acc_q[k] <= 32'd0;
      end
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      bank_q      <= bank_d;
      set_val_q   <= set_val_d;
      in_off_q    <= in_off_d;
      flt_off_q   <= flt_off_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      for (int k = 0; k < NUM_ACC; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

  assign cmd_ready             = cmd_ready_q;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;

endmodule

// File: tb/tb_cfu_simd_mac_banked.sv
// Self-checking bench: directed vector table, handshake corner cases and
// randomized commands against an arithmetic reference model (8- and 16-bit lanes).
module tb_cfu_simd_mac_banked;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        cmd_valid_s = 1'b0;
  logic        rsp_ready_s = 1'b0;
  logic [9:0]  fid_s = 10'd0;
  logic [31:0] a_s = 32'd0;
  logic [31:0] b_s = 32'd0;

  logic        cr8, rv8, cr16, rv16;
  logic [31:0] out8, out16;
  logic        cr_m, rv_m;
  logic [31:0] out_m;

  assign cr_m  = sel ? cr16 : cr8;
  assign rv_m  = sel ? rv16 : rv8;
  assign out_m = sel ? out16 : out8;

  cfu_simd_mac_banked #(.ELEM_W(8), .NUM_ACC(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid_s & ~sel), .cmd_ready(cr8),
    .cmd_payload_function_id(fid_s),
    .cmd_payload_inputs_0(a_s), .cmd_payload_inputs_1(b_s),
    .rsp_valid(rv8), .rsp_ready(rsp_ready_s & ~sel),
    .rsp_payload_outputs_0(out8)
  );

  cfu_simd_mac_banked #(.ELEM_W(16), .NUM_ACC(4)) dut16 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid_s & sel), .cmd_ready(cr16),
    .cmd_payload_function_id(fid_s),
    .cmd_payload_inputs_0(a_s), .cmd_payload_inputs_1(b_s),
    .rsp_valid(rv16), .rsp_ready(rsp_ready_s & sel),
    .rsp_payload_outputs_0(out16)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: per-instance accumulators and offsets.
  logic [31:0] acc_m [2][4];
  logic [31:0] in_off_m [2];
  logic [31:0] flt_off_m [2];

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      in_off_m[s] = 32'd0;
      flt_off_m[s] = 32'd0;
      for (int k = 0; k < 4; k++) acc_m[s][k] = 32'd0;
    end
  endfunction

  function automatic logic [31:0] model(input bit s, input logic [6:0] op,
                                        input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    int bk = int'(f3) % 4;
    int lanes = s ? 2 : 4;
    logic [31:0] sum = 32'd0;
    logic [31:0] ea, eb, r;
    for (int i = 0; i < lanes; i++) begin
      if (s) begin
        ea = 32'($signed(a[16*i +: 16]));
        eb = 32'($signed(b[16*i +: 16]));
      end else begin
        ea = 32'($signed(a[8*i +: 8]));
        eb = 32'($signed(b[8*i +: 8]));
      end
      sum = sum + (ea + in_off_m[s]) * (eb + flt_off_m[s]);
    end
    case (op)
      7'd0: begin acc_m[s][bk] = acc_m[s][bk] + sum; r = acc_m[s][bk]; end
      7'd1: begin in_off_m[s] = a; r = 32'd0; end
      7'd2: begin flt_off_m[s] = a; r = 32'd0; end
      7'd3: r = acc_m[s][bk];
      7'd4: begin r = acc_m[s][bk]; acc_m[s][bk] = 32'd0; end
      7'd5: begin for (int k = 0; k < 4; k++) acc_m[s][k] = 32'd0; r = 32'd0; end
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  // Issue one command, check 2-cycle latency, optionally stall the response.
  task automatic run_cmd(input bit s, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input int hold,
                         output logic [31:0] res);
    int n = 0;
    sel = s; fid_s = {op, f3}; a_s = a; b_s = b; cmd_valid_s = 1'b1;
    while (!cr_m && n < 50) begin @(negedge clk); n++; end
    if (!cr_m) begin
      check("cmd_ready_timeout", 32'(cr_m), 32'd1);
      cmd_valid_s = 1'b0; res = 32'hxxxx_xxxx;
      return;
    end
    @(negedge clk);
    cmd_valid_s = 1'b0;
    check("lat_exec_rsp_valid", 32'(rv_m), 32'd0);
    @(negedge clk);
    check("lat_resp_rsp_valid", 32'(rv_m), 32'd1);
    n = 0;
    while (!rv_m && n < 10) begin @(negedge clk); n++; end
    res = out_m;
    if (hold > 0) begin
      fid_s = {7'd5, 3'd0}; cmd_valid_s = 1'b1;
      for (int h = 0; h < hold; h++) begin
        check("hold_rsp_valid", 32'(rv_m), 32'd1);
        check("hold_payload", out_m, res);
        check("hold_cmd_ready", 32'(cr_m), 32'd0);
        @(negedge clk);
      end
      cmd_valid_s = 1'b0;
    end
    rsp_ready_s = 1'b1;
    @(negedge clk);
    rsp_ready_s = 1'b0;
    check("rsp_released", 32'(rv_m), 32'd0);
  endtask

  typedef struct {
    bit          s;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] res, exp_v;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    vecs.push_back('{1'b0, 7'd1, 3'd0, 32'd128,       32'd0,         32'd0});
    vecs.push_back('{1'b0, 7'd0, 3'd0, 32'h01010101,  32'h02020202,  32'd1032});
    vecs.push_back('{1'b0, 7'd3, 3'd0, 32'd0,         32'd0,         32'd1032});
    vecs.push_back('{1'b0, 7'd1, 3'd0, 32'd0,         32'd0,         32'd0});
    vecs.push_back('{1'b0, 7'd0, 3'd1, 32'hFFFFFFFF,  32'h01010101,  32'hFFFFFFFC});
    vecs.push_back('{1'b0, 7'd3, 3'd0, 32'd0,         32'd0,         32'd1032});
    vecs.push_back('{1'b0, 7'd0, 3'd2, 32'd7,         32'd1,         32'd7});
    vecs.push_back('{1'b0, 7'd4, 3'd2, 32'd0,         32'd0,         32'd7});
    vecs.push_back('{1'b0, 7'd3, 3'd2, 32'd0,         32'd0,         32'd0});
    vecs.push_back('{1'b0, 7'd3, 3'd5, 32'd0,         32'd0,         32'hFFFFFFFC});
    vecs.push_back('{1'b0, 7'd6, 3'd0, 32'h12345678,  32'd1,         32'hDEADBEEF});
    vecs.push_back('{1'b0, 7'd3, 3'd0, 32'd0,         32'd0,         32'd1032});
    vecs.push_back('{1'b0, 7'd0, 3'd3, 32'd1,         32'd1,         32'd1});
    vecs.push_back('{1'b0, 7'd0, 3'd3, 32'd1,         32'd1,         32'd2});
    vecs.push_back('{1'b0, 7'd2, 3'd0, 32'hFFFFFFFF,  32'd0,         32'd0});
    vecs.push_back('{1'b0, 7'd0, 3'd3, 32'd3,         32'd0,         32'hFFFFFFFF});
    vecs.push_back('{1'b0, 7'd5, 3'd0, 32'd0,         32'd0,         32'd0});
    vecs.push_back('{1'b0, 7'd3, 3'd1, 32'd0,         32'd0,         32'd0});
    vecs.push_back('{1'b1, 7'd2, 3'd0, 32'd1,         32'd0,         32'd0});
    vecs.push_back('{1'b1, 7'd0, 3'd0, 32'h0003FFFE,  32'h00010002,  32'd0});
    vecs.push_back('{1'b1, 7'd0, 3'd1, 32'h00020003,  32'h00040005,  32'd28});
    vecs.push_back('{1'b1, 7'd3, 3'd1, 32'd0,         32'd0,         32'd28});

    repeat (3) @(negedge clk);
    check("reset_rsp_valid", 32'(rv8), 32'd0);
    check("reset_payload", out8, 32'd0);
    check("reset_rsp_valid16", 32'(rv16), 32'd0);
    reset = 1'b0;
    check("reset_cmd_ready", 32'(cr8), 32'd1);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].s, vecs[i].op, vecs[i].f3, vecs[i].a, vecs[i].b, 0, res);
      exp_v = model(vecs[i].s, vecs[i].op, vecs[i].f3, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d", i), res, vecs[i].exp);
    end

    // Stalled response; a CLR_ALL offered meanwhile must not be taken.
    run_cmd(1'b0, 7'd0, 3'd0, 32'h05, 32'h05, 5, res);
    check("stall_mac", res, model(1'b0, 7'd0, 3'd0, 32'h05, 32'h05));
    run_cmd(1'b0, 7'd3, 3'd0, 32'd0, 32'd0, 0, res);
    check("stall_no_extra_cmd", res, model(1'b0, 7'd3, 3'd0, 32'd0, 32'd0));

    // rsp_ready while idle is ignored.
    sel = 1'b0; rsp_ready_s = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready_rsp_valid", 32'(rv8), 32'd0);
    check("idle_ready_cmd_ready", 32'(cr8), 32'd1);
    rsp_ready_s = 1'b0;

    for (int i = 0; i < 80; i++) begin
      bit s = (i % 3) == 0;
      logic [6:0] op = ($urandom % 2 == 0) ? 7'd0 : 7'($urandom_range(0, 7));
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      int hold = $urandom_range(0, 2);
      run_cmd(s, op, f3, a, b, hold, res);
      check($sformatf("rand%0d_op%0d", i, op), res, model(s, op, f3, a, b));
    end

    // Reset while a MAC is in EXEC.
    run_cmd(1'b0, 7'd1, 3'd0, 32'd9, 32'd0, 0, res);
    sel = 1'b0; fid_s = {7'd0, 3'd0}; a_s = 32'h01010101; b_s = 32'h01010101;
    cmd_valid_s = 1'b1;
    @(negedge clk);
    cmd_valid_s = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midreset_rsp_valid", 32'(rv8), 32'd0);
    check("midreset_payload", out8, 32'd0);
    reset = 1'b0;
    model_reset();
    check("midreset_cmd_ready", 32'(cr8), 32'd1);
    for (int k = 0; k < 4; k++) begin
      run_cmd(1'b0, 7'd3, 3'(k), 32'd0, 32'd0, 0, res);
      check($sformatf("midreset_read_b%0d", k), res, 32'd0);
    end
    run_cmd(1'b1, 7'd3, 3'd1, 32'd0, 32'd0, 0, res);
    check("midreset_read16_b1", res, 32'd0);
    run_cmd(1'b0, 7'd0, 3'd0, 32'h01010101, 32'h01010101, 0, res);
    check("midreset_offsets_cleared", res, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
